// File: rtl/rx_framing_parser.sv
// ---------------------------------------------------------------------------
// rx_framing_parser
//   Scans a 64-byte received symbol beat for physical-layer framing tokens
//   (STP/SDP/END/EDB) and produces per-byte packet flags, one cycle later.
//   Parse state and the packet length counter carry across beats, so packets
//   may span any number of beats and several may start/end inside one beat.
//
//   Optional feature: define RX_FRAMER_ERRCNT_EN to build the saturating
//   framing-error counter; otherwise errCount is tied to zero.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   symData      512-bit beat, byte k = bits [8k+7:8k], byte 0 earliest
//   symK         per-byte K-symbol indicator
//   beatValid    symData/symK carry a beat this cycle
//   packetData   symData registered (zero when no beat)
//   packetValid  byte is packet payload
//   tlpstart     byte is STP       tlpend    byte is END closing a TLP
//   dllpstart    byte is SDP       dllpend   byte is END closing a DLLP
//   edb          byte is EDB closing (nullifying) a TLP
//   framingErr   one-cycle pulse: framing violation in the registered beat
//   errCount     saturating count of framingErr pulses
// ---------------------------------------------------------------------------
module rx_framing_parser (
  input  logic         clk,
  input  logic         reset,
  input  logic [511:0] symData,
  input  logic [63:0]  symK,
  input  logic         beatValid,
  output logic [511:0] packetData,
  output logic [63:0]  packetValid,
  output logic [63:0]  tlpstart,
  output logic [63:0]  tlpend,
  output logic [63:0]  dllpstart,
  output logic [63:0]  dllpend,
  output logic [63:0]  edb,
  output logic         framingErr,
  output logic [15:0]  errCount
);

  localparam logic [7:0]  SYM_STP     = 8'hFB;
  localparam logic [7:0]  SYM_SDP     = 8'h5C;
  localparam logic [7:0]  SYM_END     = 8'hFD;
  localparam logic [7:0]  SYM_EDB     = 8'hFE;
  localparam logic [12:0] TLP_MAX_LEN = 13'd4112;
  localparam logic [12:0] DLLP_LEN    = 13'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TLP  = 2'd1,
    ST_DLLP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [12:0]   cnt_q, cnt_d;

  // Parse state and length count as seen on entry to each byte of the beat.
  state_e        st_in  [64];
  logic [12:0]   cnt_in [64];
  state_e        st_walk;
  logic [12:0]   cnt_walk;

  logic [7:0]    sym_byte [64];

  logic [511:0]  packet_data_q, packet_data_d;
  logic [63:0]   packet_valid_q, packet_valid_d;
  logic [63:0]   tlp_start_q, tlp_start_d;
  logic [63:0]   tlp_end_q, tlp_end_d;
  logic [63:0]   dllp_start_q, dllp_start_d;
  logic [63:0]   dllp_end_q, dllp_end_d;
  logic [63:0]   edb_q, edb_d;
  logic          framing_err_q, framing_err_d;

  for (genvar gi = 0; gi < 64; gi++) begin : g_byte
    assign sym_byte[gi] = symData[8*gi +: 8];
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: walk the 64 bytes in arrival order. An offending byte is
  // consumed by the error and never re-examined as a start token.
  always_comb begin
    st_walk  = state_q;
    cnt_walk = cnt_q;
    st_in    = '{default: ST_IDLE};
    cnt_in   = '{default: '0};
    for (int k = 0; k < 64; k++) begin
      st_in[k]  = st_walk;
      cnt_in[k] = cnt_walk;
      case (st_walk)
        ST_IDLE: begin
          if (symK[k] && sym_byte[k] == SYM_STP) begin
            st_walk  = ST_TLP;
            cnt_walk = '0;
          end else if (symK[k] && sym_byte[k] == SYM_SDP) begin
            st_walk  = ST_DLLP;
            cnt_walk = '0;
          end
        end
        ST_TLP: begin
          // Any K symbol ends the TLP (END, EDB or a violation); so does
          // a payload byte beyond the maximum length.
          if (symK[k] || cnt_walk == TLP_MAX_LEN) st_walk = ST_IDLE;
          else                                    cnt_walk = cnt_walk + 13'd1;
        end
        ST_DLLP: begin
          if (symK[k] || cnt_walk == DLLP_LEN) st_walk = ST_IDLE;
          else                                 cnt_walk = cnt_walk + 13'd1;
        end
        default: st_walk = ST_IDLE;
      endcase
    end
    state_d = beatValid ? st_walk  : state_q;
    cnt_d   = beatValid ? cnt_walk : cnt_q;
  end

  // Outputs: classify each byte against the state it was parsed in.
  always_comb begin
    packet_valid_d = '0;
    tlp_start_d    = '0;
    tlp_end_d      = '0;
    dllp_start_d   = '0;
    dllp_end_d     = '0;
    edb_d          = '0;
    framing_err_d  = 1'b0;
    for (int k = 0; k < 64; k++) begin
      case (st_in[k])
        ST_IDLE: begin
          if (symK[k] && sym_byte[k] == SYM_STP)      tlp_start_d[k]  = 1'b1;
          else if (symK[k] && sym_byte[k] == SYM_SDP) dllp_start_d[k] = 1'b1;
        end
        ST_TLP: begin
          if (!symK[k]) begin
            if (cnt_in[k] == TLP_MAX_LEN) framing_err_d     = 1'b1;
            else                          packet_valid_d[k] = 1'b1;
          end else if (sym_byte[k] == SYM_END) begin
            tlp_end_d[k] = 1'b1;
          end else if (sym_byte[k] == SYM_EDB) begin
            edb_d[k] = 1'b1;
          end else begin
            framing_err_d = 1'b1;
          end
        end
        ST_DLLP: begin
          if (cnt_in[k] == DLLP_LEN) begin
            if (symK[k] && sym_byte[k] == SYM_END) dllp_end_d[k] = 1'b1;
            else                                   framing_err_d = 1'b1;
          end else if (symK[k]) begin
            framing_err_d = 1'b1;
          end else begin
            packet_valid_d[k] = 1'b1;
          end
        end
        default: ;
      endcase
    end
    packet_data_d = beatValid ? symData : '0;
    if (!beatValid) begin
      packet_valid_d = '0;
      tlp_start_d    = '0;
      tlp_end_d      = '0;
      dllp_start_d   = '0;
      dllp_end_d     = '0;
      edb_d          = '0;
      framing_err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      packet_data_q  <= '0;
      packet_valid_q <= '0;
      tlp_start_q    <= '0;
      tlp_end_q      <= '0;
      dllp_start_q   <= '0;
      dllp_end_q     <= '0;
      edb_q          <= '0;
      framing_err_q  <= 1'b0;
    end else begin
      packet_data_q  <= packet_data_d;
      packet_valid_q <= packet_valid_d;
      tlp_start_q    <= tlp_start_d;
      tlp_end_q      <= tlp_end_d;
      dllp_start_q   <= dllp_start_d;
      dllp_end_q     <= dllp_end_d;
      edb_q          <= edb_d;
      framing_err_q  <= framing_err_d;
    end
  end

  assign packetData  = packet_data_q;
  assign packetValid = packet_valid_q;
  assign tlpstart    = tlp_start_q;
  assign tlpend      = tlp_end_q;
  assign dllpstart   = dllp_start_q;
  assign dllpend     = dllp_end_q;
  assign edb         = edb_q;
  assign framingErr  = framing_err_q;

`ifdef RX_FRAMER_ERRCNT_EN
  logic [15:0] err_count_q, err_count_d;

  // One increment per erroneous beat, holding at all-ones.
  always_comb begin
    err_count_d = err_count_q;
    if (framing_err_d && err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_count_q <= '0;
    else        err_count_q <= err_count_d;
  end

  assign errCount = err_count_q;
`else
  assign errCount = 16'd0;
`endif

endmodule

// File: tb/tb_rx_framing_parser.sv
module tb_rx_framing_parser;

  logic         clk = 1'b0;
  logic         reset;
  logic [511:0] symData;
  logic [63:0]  symK;
  logic         beatValid;
  logic [511:0] packetData;
  logic [63:0]  packetValid, tlpstart, tlpend, dllpstart, dllpend, edb;
  logic         framingErr;
  logic [15:0]  errCount;

  always #5 clk = ~clk;

  rx_framing_parser dut (
    .clk        (clk),
    .reset      (reset),
    .symData    (symData),
    .symK       (symK),
    .beatValid  (beatValid),
    .packetData (packetData),
    .packetValid(packetValid),
    .tlpstart   (tlpstart),
    .tlpend     (tlpend),
    .dllpstart  (dllpstart),
    .dllpend    (dllpend),
    .edb        (edb),
    .framingErr (framingErr),
    .errCount   (errCount)
  );

`ifdef RX_FRAMER_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  // beat under construction
  logic [511:0] bd;
  logic [63:0]  bk;

  // reference model: where we are in the symbol stream
  int m_mode;    // 0 = between packets, 1 = inside TLP, 2 = inside DLLP
  int m_len;     // payload bytes seen in the current packet
  int m_errcnt;

  logic [511:0] e_pd;
  logic [63:0]  e_pv, e_ts, e_te, e_ds, e_de, e_edb;
  logic         e_err;
  logic [15:0]  e_cnt;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".packetData"},  packetData,  e_pd);
    chk({tag, ".packetValid"}, packetValid, e_pv);
    chk({tag, ".tlpstart"},    tlpstart,    e_ts);
    chk({tag, ".tlpend"},      tlpend,      e_te);
    chk({tag, ".dllpstart"},   dllpstart,   e_ds);
    chk({tag, ".dllpend"},     dllpend,     e_de);
    chk({tag, ".edb"},         edb,         e_edb);
    chk({tag, ".framingErr"},  framingErr,  e_err);
    chk({tag, ".errCount"},    errCount,    e_cnt);
  endtask

  task automatic clr();
    bd = '0;
    bk = '0;
  endtask

  task automatic put(input int idx, input logic [7:0] b, input logic isk);
    bd[8*idx +: 8] = b;
    bk[idx]        = isk;
  endtask

  task automatic put_data(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) put(i, 8'($urandom_range(0, 255)), 1'b0);
  endtask

  task automatic clear_expect();
    e_pd = '0; e_pv = '0; e_ts = '0; e_te = '0; e_ds = '0; e_de = '0; e_edb = '0;
    e_err = 1'b0;
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_len = 0;
    m_errcnt = 0;
    clear_expect();
    e_cnt = '0;
  endtask

  // Framing rules applied byte by byte to the received stream.
  task automatic model_beat(input logic [511:0] d, input logic [63:0] kf, input logic v);
    logic [7:0] b;
    logic       isk;
    clear_expect();
    if (v) begin
      e_pd = d;
      for (int i = 0; i < 64; i++) begin
        b = d[8*i +: 8];
        isk = kf[i];
        if (m_mode == 0) begin
          if (isk && b == 8'hFB) begin e_ts[i] = 1'b1; m_mode = 1; m_len = 0; end
          else if (isk && b == 8'h5C) begin e_ds[i] = 1'b1; m_mode = 2; m_len = 0; end
        end else if (m_mode == 1) begin
          if (!isk) begin
            if (m_len < 4112) begin e_pv[i] = 1'b1; m_len++; end
            else begin e_err = 1'b1; m_mode = 0; end
          end else begin
            if (b == 8'hFD) e_te[i] = 1'b1;
            else if (b == 8'hFE) e_edb[i] = 1'b1;
            else e_err = 1'b1;
            m_mode = 0;
          end
        end else begin
          if (m_len == 6) begin
            if (isk && b == 8'hFD) e_de[i] = 1'b1;
            else e_err = 1'b1;
            m_mode = 0;
          end else if (isk) begin
            e_err = 1'b1;
            m_mode = 0;
          end else begin
            e_pv[i] = 1'b1;
            m_len++;
          end
        end
      end
      if (e_err && m_errcnt < 65535) m_errcnt++;
    end
    e_cnt = CNT_EN ? 16'(m_errcnt) : 16'd0;
  endtask

  // Drive one cycle (called #1 after a rising edge), then check the result.
  task automatic beat(input logic v, input string tag);
    symData = bd;
    symK = bk;
    beatValid = v;
    model_beat(bd, bk, v);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic random_byte(input int idx);
    int r;
    r = $urandom_range(0, 99);
    if (r < 55)      put(idx, 8'($urandom_range(0, 255)), 1'b0);
    else if (r < 63) put(idx, 8'hFB, 1'b1);
    else if (r < 71) put(idx, 8'h5C, 1'b1);
    else if (r < 82) put(idx, 8'hFD, 1'b1);
    else if (r < 87) put(idx, 8'hFE, 1'b1);
    else             put(idx, 8'hBC, 1'b1);
  endtask

  initial begin
    reset = 1'b0;
    symData = '0;
    symK = '0;
    beatValid = 1'b0;
    model_reset();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b1;

    // single TLP inside one beat
    clr(); put(0, 8'hFB, 1'b1); put_data(1, 20); put(21, 8'hFD, 1'b1);
    beat(1'b1, "tlp_basic");
    chk("tlp_basic.valid_const", packetValid, 64'h0000_0000_001F_FFFE);
    chk("tlp_basic.end_const",   tlpend,      64'h0000_0000_0020_0000);

    // DLLP spanning two beats
    clr(); put(60, 8'h5C, 1'b1); put_data(61, 63);
    beat(1'b1, "dllp_span0");
    chk("dllp_span0.start_const", dllpstart,   64'h1000_0000_0000_0000);
    chk("dllp_span0.valid_const", packetValid, 64'hE000_0000_0000_0000);
    clr(); put_data(0, 2); put(3, 8'hFD, 1'b1);
    beat(1'b1, "dllp_span1");
    chk("dllp_span1.end_const",   dllpend,     64'h0000_0000_0000_0008);
    chk("dllp_span1.valid_const", packetValid, 64'h0000_0000_0000_0007);

    // EDB terminates TLP; following data is dropped
    clr(); put(0, 8'hFB, 1'b1); put_data(1, 4); put(5, 8'hFE, 1'b1); put_data(6, 63);
    beat(1'b1, "tlp_edb");
    chk("tlp_edb.edb_const", edb, 64'h20);
    clr(); put_data(0, 63);
    beat(1'b1, "after_edb");
    chk("after_edb.valid_const", packetValid, 64'h0);

    // short DLLP is a framing error
    clr(); put(0, 8'h5C, 1'b1); put_data(1, 4); put(5, 8'hFD, 1'b1);
    beat(1'b1, "dllp_short");
    chk("dllp_short.err_const", framingErr, 1'b1);
    chk("dllp_short.cnt_const", errCount, CNT_EN ? 16'd1 : 16'd0);

    // 7th DLLP byte not END, then a second violation in the same beat
    clr(); put(0, 8'h5C, 1'b1); put_data(1, 7); put(10, 8'hFB, 1'b1); put(11, 8'hBC, 1'b1);
    beat(1'b1, "dllp_long_multi");
    chk("dllp_long_multi.valid_const", packetValid, 64'h0000_0000_0000_007E);
    chk("dllp_long_multi.cnt_const", errCount, CNT_EN ? 16'd2 : 16'd0);

    // stall in the middle of a TLP
    clr(); put(62, 8'hFB, 1'b1); put_data(63, 63);
    beat(1'b1, "stall_start");
    for (int s = 0; s < 3; s++) begin
      bd = {16{$urandom}};
      bk = {$urandom, $urandom};
      beat(1'b0, "stall_idle");
    end
    clr(); put_data(0, 9); put(10, 8'hFD, 1'b1);
    beat(1'b1, "stall_resume");
    chk("stall_resume.valid_const", packetValid, 64'h3FF);
    chk("stall_resume.end_const",   tlpend,      64'h400);

    // reset mid-packet
    clr(); put(0, 8'hFB, 1'b1); put_data(1, 5);
    beat(1'b1, "rst_mid_start");
    clr(); put_data(0, 9); put(10, 8'hFD, 1'b1);
    symData = bd; symK = bk; beatValid = 1'b1;
    reset = 1'b0;
    model_reset();
    #2;
    check_all("rst_async");
    @(posedge clk);
    #1;
    reset = 1'b1;
    beat(1'b1, "rst_mid_after");
    chk("rst_mid_after.valid_const", packetValid, 64'h0);
    chk("rst_mid_after.end_const",   tlpend,      64'h0);
    chk("rst_mid_after.err_const",   framingErr,  1'b0);

    // maximum-length TLP (4112 bytes) ends cleanly; one more byte overflows
    for (int ov = 0; ov < 2; ov++) begin
      clr(); put(0, 8'hFB, 1'b1); put_data(1, 63);
      beat(1'b1, "tlp_max_head");
      for (int j = 0; j < 63; j++) begin
        clr(); put_data(0, 63);
        beat(1'b1, "tlp_max_body");
      end
      clr(); put_data(0, 16);
      if (ov == 0) put(17, 8'hFD, 1'b1);
      else         put_data(17, 17);
      beat(1'b1, ov == 0 ? "tlp_max_end" : "tlp_overflow");
      chk("tlp_max.valid_const", packetValid, 64'h1_FFFF);
      chk("tlp_max.err", framingErr, ov == 0 ? 1'b0 : 1'b1);
    end

    // randomized beats against the reference model
    for (int n = 0; n < 300; n++) begin
      clr();
      for (int i = 0; i < 64; i++) random_byte(i);
      beat($urandom_range(0, 9) != 0, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
